// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and state encodings for the PS/2 keystroke decoder.
// Exports: KEY_NONE / KEY_UNMAPPED letter codes, SC_BREAK / SC_EXT scan-code
// prefixes, frame_state_e (serial frame FSM), decode_state_e (make/break FSM).
package ps2_pkg;

  localparam logic [4:0] KEY_NONE     = 5'b11111;  // nothing pressed since reset
  localparam logic [4:0] KEY_UNMAPPED = 5'b00000;  // last make was not a letter
  localparam logic [7:0] SC_BREAK     = 8'hF0;
  localparam logic [7:0] SC_EXT       = 8'hE0;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_e;

  typedef enum logic [1:0] {
    DC_MAKE,
    DC_BRK,
    DC_EXT,
    DC_EXT_BRK
  } decode_state_e;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: keystroke bundle from the PS/2 decoder to its consumer.
// Signals: keystroke[4:0] letter code, keyReleased one-cycle release strobe,
// frameError one-cycle dropped-frame strobe. master = decoder, slave = consumer.
interface ps2_key_decoder_if;
  logic [4:0] keystroke;
  logic       keyReleased;
  logic       frameError;

  modport master (output keystroke, output keyReleased, output frameError);
  modport slave  (input  keystroke, input  keyReleased, input  frameError);
endinterface

// File: rtl/ps2_letter_map.sv
// ps2_letter_map: combinational scan-code-set-2 to letter code lookup (a=1 .. z=26).
// Ports: scan_code_i[7:0] raw make code in, letter_o[4:0] letter code out;
// any code that is not a letter key yields KEY_UNMAPPED.
module ps2_letter_map
  import ps2_pkg::*;
(
  input  logic [7:0] scan_code_i,
  output logic [4:0] letter_o
);

  always_comb begin
    letter_o = KEY_UNMAPPED;
    case (scan_code_i)
      8'h1C: letter_o = 5'd1;
      8'h32: letter_o = 5'd2;
      8'h21: letter_o = 5'd3;
      8'h23: letter_o = 5'd4;
      8'h24: letter_o = 5'd5;
      8'h2B: letter_o = 5'd6;
      8'h34: letter_o = 5'd7;
      8'h33: letter_o = 5'd8;
      8'h43: letter_o = 5'd9;
      8'h3B: letter_o = 5'd10;
      8'h42: letter_o = 5'd11;
      8'h4B: letter_o = 5'd12;
      8'h3A: letter_o = 5'd13;
      8'h31: letter_o = 5'd14;
      8'h44: letter_o = 5'd15;
      8'h4D: letter_o = 5'd16;
      8'h15: letter_o = 5'd17;
      8'h2D: letter_o = 5'd18;
      8'h1B: letter_o = 5'd19;
      8'h2C: letter_o = 5'd20;
      8'h3C: letter_o = 5'd21;
      8'h2A: letter_o = 5'd22;
      8'h1D: letter_o = 5'd23;
      8'h22: letter_o = 5'd24;
      8'h35: letter_o = 5'd25;
      8'h1A: letter_o = 5'd26;
      default: letter_o = KEY_UNMAPPED;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver (scan code set 2) driving letter keystrokes.
// Ports: clk, reset (async, active-high), ps2_clk / ps2_data raw async pins,
// key_if (master): keystroke[4:0], keyReleased strobe, frameError strobe.
// Latency: keystroke / keyReleased update 2 clk cycles after the filtered
// falling edge that samples the stop bit. No backpressure: the keyboard cannot
// be stalled, outputs are plain registered levels/strobes.
// Build option: define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_key_decoder_if.master key_if
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

  // ---------------- input conditioning ----------------
  logic [1:0]     clk_sync_q, dat_sync_q;
  logic           filt_q, filt_prev_q;
  logic [FCW-1:0] filt_cnt_q;
  logic           fall;
  logic           dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2_data};
      filt_prev_q <= filt_q;
      // Accept a new level only after FILTER_LEN consecutive differing samples;
      // any sample matching the current level restarts the run.
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_LAST) begin
        filt_q     <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;
  assign dat  = dat_sync_q[1];

  // ---------------- frame FSM ----------------
  frame_state_e   fr_state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     byte_q;
  logic [TCW-1:0] tmo_cnt_q;
  logic           byte_vld_q;
  logic           ferr_q;
`ifdef PS2_PARITY_CHECK_EN
  logic           parity_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fr_state_q <= FR_IDLE;
      bit_cnt_q  <= '0;
      byte_q     <= '0;
      tmo_cnt_q  <= '0;
      byte_vld_q <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      byte_vld_q <= 1'b0;
      ferr_q     <= 1'b0;

      // Idle-gap counter: only runs while a frame is in flight.
      if (fr_state_q == FR_IDLE || fall) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      if (fr_state_q != FR_IDLE && !fall && tmo_cnt_q == TMO_LAST) begin
        // Keyboard went quiet mid-frame: abandon the partial byte.
        fr_state_q <= FR_IDLE;
        ferr_q     <= 1'b1;
      end else if (fall) begin
        case (fr_state_q)
          FR_IDLE: begin
            if (!dat) begin
              fr_state_q <= FR_DATA;
              bit_cnt_q  <= '0;
            end
          end
          FR_DATA: begin
            byte_q    <= {dat, byte_q[7:1]};  // LSB arrives first
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) fr_state_q <= FR_PARITY;
          end
          FR_PARITY: begin
            // Without the parity check the bit is consumed and discarded.
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= dat;
`endif
            fr_state_q <= FR_STOP;
          end
          FR_STOP: begin
            fr_state_q <= FR_IDLE;
            if (!dat) begin
              ferr_q <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
            end else if (!(^{byte_q, parity_q})) begin
              ferr_q <= 1'b1;  // odd parity violated
`endif
            end else begin
              byte_vld_q <= 1'b1;
            end
          end
          default: fr_state_q <= FR_IDLE;
        endcase
      end
    end
  end

  // ---------------- decode FSM ----------------
  logic [4:0]    letter;
  decode_state_e dc_state_q;
  logic [4:0]    held_q;
  logic [4:0]    keystroke_q;
  logic          rel_q;

  ps2_letter_map u_letter_map (
    .scan_code_i (byte_q),
    .letter_o    (letter)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc_state_q  <= DC_MAKE;
      held_q      <= KEY_UNMAPPED;
      keystroke_q <= KEY_NONE;
      rel_q       <= 1'b0;
    end else begin
      rel_q <= 1'b0;
      if (byte_vld_q) begin
        case (dc_state_q)
          DC_MAKE: begin
            if (byte_q == SC_BREAK) begin
              dc_state_q <= DC_BRK;
            end else if (byte_q == SC_EXT) begin
              dc_state_q <= DC_EXT;
            end else if (!(letter == held_q && held_q != KEY_UNMAPPED)) begin
              // A repeat of the held letter (typematic) is suppressed; an
              // unmapped make always lands as KEY_UNMAPPED.
              keystroke_q <= letter;
              held_q      <= letter;
            end
          end
          DC_BRK: begin
            if (letter == held_q && held_q != KEY_UNMAPPED) begin
              rel_q  <= 1'b1;
              held_q <= KEY_UNMAPPED;
            end
            dc_state_q <= DC_MAKE;
          end
          DC_EXT: begin
            dc_state_q <= (byte_q == SC_BREAK) ? DC_EXT_BRK : DC_MAKE;
          end
          DC_EXT_BRK: dc_state_q <= DC_MAKE;
          default:    dc_state_q <= DC_MAKE;
        endcase
      end
    end
  end

  assign key_if.keystroke   = keystroke_q;
  assign key_if.keyReleased = rel_q;
  assign key_if.frameError  = ferr_q;

endmodule
